ramb4_s1_byte_ctrl: RTL and testbench

RAMB4_S1_BYTE_CTRL -- requirements
Module: ramb4_s1_byte_ctrl

---
 rtl/ramb4_s1_pkg.sv | 24 ++
 rtl/ramb4_s1.sv | 33 +++
 rtl/ramb4_s1_byte_ctrl.sv | 136 +++++++++++++
 tb/tb_ramb4_s1_byte_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramb4_s1_pkg.sv
// Shared definitions for the byte-wide controller in front of a 4096x1 RAM.
package ramb4_s1_pkg;

  localparam int RAM_DEPTH = 4096;
  localparam int RAM_AW    = 12;
  localparam int BYTE_AW   = 9;
  localparam int BYTE_BITS = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    LAST  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Maps the bit position inside a byte's RAM slot to the data bit it holds.
  function automatic logic [IDX_W-1:0] dataBitIndex(input logic [IDX_W-1:0] ramIdx,
                                                    input logic msbAtLow);
    return msbAtLow ? IDX_W'(3'd7 - ramIdx) : ramIdx;
  endfunction

endpackage

// File: rtl/ramb4_s1.sv
// Behavioural 4096x1 synchronous single-port RAM with the RAMB4_S1 pinout.
// Write-first output, synchronous output reset, all activity gated by EN.
module RAMB4_S1
  import ramb4_s1_pkg::*;
(
  output logic              DO,
  input  logic [RAM_AW-1:0] ADDR,
  input  logic              CLK,
  input  logic              DI,
  input  logic              EN,
  input  logic              RST,
  input  logic              WE
);

  logic mem [0:RAM_DEPTH-1];

  // One enabled access per clock: optional write, output register update.
  always_ff @(posedge CLK) begin
    if (EN) begin
      if (WE) begin
        mem[ADDR] <= DI;
      end
      if (RST) begin
        DO <= 1'b0;
      end else if (WE) begin
        DO <= DI;
      end else begin
        DO <= mem[ADDR];
      end
    end
  end

endmodule

// File: rtl/ramb4_s1_byte_ctrl.sv
// Byte read/write controller that serialises each byte into eight
// consecutive bit accesses of a 4096x1 synchronous RAM.
module ramb4_s1_byte_ctrl
  import ramb4_s1_pkg::*;
#(
  parameter int MSB_AT_LOW = 0
)
(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_WE,
  input  logic [BYTE_AW-1:0]   REQ_ADDR,
  input  logic [BYTE_BITS-1:0] REQ_WDATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [BYTE_BITS-1:0] RSP_RDATA,
  output logic [RAM_AW-1:0]    RAM_ADDR,
  output logic                 RAM_DI,
  output logic                 RAM_EN,
  output logic                 RAM_WE,
  output logic                 RAM_RST,
  input  logic                 RAM_DO
);

  localparam logic MSB_LOW = (MSB_AT_LOW != 0);

  state_e               state_q, state_d;
  logic [BYTE_AW-1:0]   addr_q, addr_d;
  logic [BYTE_BITS-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [BYTE_BITS-1:0] rdBuf_q, rdBuf_d;
  logic [BYTE_BITS-1:0] rspData_q, rspData_d;
  logic [RAM_AW-1:0]    lastAddr_q, lastAddr_d;

  logic [IDX_W-1:0]     prevIdx;
  logic [RAM_AW-1:0]    ramAddr;
  logic                 ramEn;
  logic                 ramWe;
  logic                 ramDi;

  // Next-state, datapath updates and RAM drive for every FSM state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdBuf_d    = rdBuf_q;
    rspData_d  = rspData_q;
    lastAddr_d = lastAddr_q;
    ramAddr    = lastAddr_q;
    ramEn      = 1'b0;
    ramWe      = 1'b0;
    ramDi      = 1'b0;
    prevIdx    = IDX_W'(cnt_q - 3'd1);

    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          cnt_d   = '0;
          state_d = REQ_WE ? WRITE : READ;
        end
      end
      WRITE: begin
        ramEn      = 1'b1;
        ramWe      = 1'b1;
        ramAddr    = {addr_q, cnt_q};
        ramDi      = wdata_q[dataBitIndex(cnt_q, MSB_LOW)];
        lastAddr_d = ramAddr;
        cnt_d      = IDX_W'(cnt_q + 3'd1);
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      READ: begin
        ramEn      = 1'b1;
        ramAddr    = {addr_q, cnt_q};
        lastAddr_d = ramAddr;
        cnt_d      = IDX_W'(cnt_q + 3'd1);
        if (cnt_q != 3'd0) begin
          rdBuf_d[dataBitIndex(prevIdx, MSB_LOW)] = RAM_DO;
        end
        if (cnt_q == 3'd7) begin
          state_d = LAST;
        end
      end
      LAST: begin
        rdBuf_d[dataBitIndex(prevIdx, MSB_LOW)] = RAM_DO;
        rspData_d = rdBuf_d;
        state_d   = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdBuf_q    <= '0;
      rspData_q  <= '0;
      lastAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdBuf_q    <= rdBuf_d;
      rspData_q  <= rspData_d;
      lastAddr_q <= lastAddr_d;
    end
  end

  assign REQ_READY = RST_N && (state_q == IDLE);
  assign RSP_VALID = (state_q == RESP);
  assign RSP_RDATA = rspData_q;
  assign RAM_ADDR  = ramAddr;
  assign RAM_EN    = ramEn;
  assign RAM_WE    = ramWe;
  assign RAM_DI    = ramDi;
  assign RAM_RST   = 1'b0;

endmodule

// File: tb/tb_ramb4_s1_byte_ctrl.sv
// Testbench: two controllers (LSB-first and MSB-first layouts) share one
// request stream, each with its own RAM, checked against a byte-level model.
module tb_ramb4_s1_byte_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       reqValid;
  logic       reqWe;
  logic [8:0] reqAddr;
  logic [7:0] reqWdata;
  logic       rspReady;

  logic        ready0, ready1;
  logic        rspValid0, rspValid1;
  logic [7:0]  rdata0, rdata1;
  logic [11:0] ramAddr0, ramAddr1;
  logic        ramDi0, ramDi1, ramEn0, ramEn1, ramWe0, ramWe1, ramRst0, ramRst1;
  logic        ramDo0, ramDo1;

  int errors = 0;
  int checks = 0;

  logic [7:0] modelMem [2][512];
  bit         known [512];
  logic [7:0] lastRsp [2];

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  ramb4_s1_byte_ctrl #(.MSB_AT_LOW(0)) dut0 (
    .CLK(clk), .RST_N(rstN), .REQ_VALID(reqValid), .REQ_READY(ready0),
    .REQ_WE(reqWe), .REQ_ADDR(reqAddr), .REQ_WDATA(reqWdata),
    .RSP_VALID(rspValid0), .RSP_READY(rspReady), .RSP_RDATA(rdata0),
    .RAM_ADDR(ramAddr0), .RAM_DI(ramDi0), .RAM_EN(ramEn0), .RAM_WE(ramWe0),
    .RAM_RST(ramRst0), .RAM_DO(ramDo0)
  );

  RAMB4_S1 ram0 (
    .DO(ramDo0), .ADDR(ramAddr0), .CLK(clk), .DI(ramDi0), .EN(ramEn0),
    .RST(ramRst0), .WE(ramWe0)
  );

  ramb4_s1_byte_ctrl #(.MSB_AT_LOW(1)) dut1 (
    .CLK(clk), .RST_N(rstN), .REQ_VALID(reqValid), .REQ_READY(ready1),
    .REQ_WE(reqWe), .REQ_ADDR(reqAddr), .REQ_WDATA(reqWdata),
    .RSP_VALID(rspValid1), .RSP_READY(rspReady), .RSP_RDATA(rdata1),
    .RAM_ADDR(ramAddr1), .RAM_DI(ramDi1), .RAM_EN(ramEn1), .RAM_WE(ramWe1),
    .RAM_RST(ramRst1), .RAM_DO(ramDo1)
  );

  RAMB4_S1 ram1 (
    .DO(ramDo1), .ADDR(ramAddr1), .CLK(clk), .DI(ramDi1), .EN(ramEn1),
    .RST(ramRst1), .WE(ramWe1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Raw RAM contents of a byte slot: bit k is RAM cell {a,k}.
  function automatic logic [7:0] ramBits(input int inst, input logic [8:0] a);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) begin
      r[k] = (inst == 0) ? ram0.mem[{a, 3'(k)}] : ram1.mem[{a, 3'(k)}];
    end
    return r;
  endfunction

  // Expected raw slot contents: cell k holds data bit k, or bit 7-k when MSB-first.
  function automatic logic [7:0] expRaw(input int inst, input logic [8:0] a);
    logic [7:0] r;
    logic [7:0] d;
    d = modelMem[inst][a];
    for (int k = 0; k < 8; k++) begin
      r[k] = (inst == 0) ? d[k] : d[7-k];
    end
    return r;
  endfunction

  task automatic checkResetOutputs();
    checkOutput("rstReady", 32'({ready0, ready1}), 32'd0);
    checkOutput("rstRspValid", 32'({rspValid0, rspValid1}), 32'd0);
    checkOutput("rstRdata", 32'({rdata0, rdata1}), 32'd0);
    checkOutput("rstRamCtl", 32'({ramEn0, ramWe0, ramDi0, ramRst0, ramEn1, ramWe1, ramDi1, ramRst1}), 32'd0);
    checkOutput("rstRamAddr", 32'({ramAddr0, ramAddr1}), 32'd0);
  endtask

  // Present a request at a falling edge and wait (bounded) for its acceptance.
  task automatic applyStimulus(input logic we, input logic [8:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    reqValid = 1'b1;
    reqWe    = we;
    reqAddr  = a;
    reqWdata = d;
    while (!(ready0 && ready1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("acceptWait", 32'(n < 40), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic writeBody(input logic [8:0] a, input logic [7:0] d);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput("wrReady", 32'({ready0, ready1}), 32'd0);
      checkOutput("wrEnWe", 32'({ramEn0, ramWe0, ramEn1, ramWe1}), 32'hF);
      checkOutput("wrAddr0", 32'(ramAddr0), 32'({a, 3'(k-1)}));
      checkOutput("wrAddr1", 32'(ramAddr1), 32'({a, 3'(k-1)}));
      checkOutput("wrDi", 32'({ramDi0, ramDi1}), 32'({d[k-1], d[8-k]}));
    end
    @(negedge clk);
    modelMem[0][a] = d;
    modelMem[1][a] = d;
    known[a] = 1'b1;
    checkOutput("wrDoneReady", 32'({ready0, ready1}), 32'h3);
    checkOutput("idleRamCtl", 32'({ramEn0, ramWe0, ramDi0, ramEn1, ramWe1, ramDi1}), 32'd0);
    checkOutput("idleAddrHold", 32'({ramAddr0, ramAddr1}), 32'({a, 3'd7, a, 3'd7}));
    checkOutput("ramBits0", 32'(ramBits(0, a)), 32'(expRaw(0, a)));
    checkOutput("ramBits1", 32'(ramBits(1, a)), 32'(expRaw(1, a)));
  endtask

  task automatic readBody(input logic [8:0] a, input int hold, input bit pulse);
    logic [7:0] e0;
    logic [7:0] e1;
    e0 = modelMem[0][a];
    e1 = modelMem[1][a];
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        checkOutput("rdEnWe", 32'({ramEn0, ramWe0, ramEn1, ramWe1}), 32'b1010);
        checkOutput("rdAddr0", 32'(ramAddr0), 32'({a, 3'(k-1)}));
        checkOutput("rdAddr1", 32'(ramAddr1), 32'({a, 3'(k-1)}));
      end
      if (k == 9) begin
        checkOutput("lastEn", 32'({ramEn0, ramEn1}), 32'd0);
      end
      if (k < 10) begin
        checkOutput("rdBusy", 32'({rspValid0, rspValid1, ready0, ready1}), 32'd0);
        checkOutput("rdRetain", 32'({rdata0, rdata1}), 32'({lastRsp[0], lastRsp[1]}));
      end else begin
        checkOutput("rspLatency", 32'({rspValid0, rspValid1}), 32'h3);
        checkOutput("rspData0", 32'(rdata0), 32'(e0));
        checkOutput("rspData1", 32'(rdata1), 32'(e1));
      end
    end
    for (int h = 0; h < hold; h++) begin
      if (pulse) begin
        reqValid = (h == 0);
      end
      reqWe    = 1'b1;
      reqAddr  = a ^ 9'h001;
      reqWdata = ~e0;
      @(negedge clk);
      checkOutput("holdValid", 32'({rspValid0, rspValid1, ready0, ready1}), 32'b1100);
      checkOutput("holdData", 32'({rdata0, rdata1}), 32'({e0, e1}));
      checkOutput("holdRamEn", 32'({ramEn0, ramEn1}), 32'd0);
    end
    reqValid = 1'b0;
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("rspDone", 32'({rspValid0, rspValid1, ready0, ready1}), 32'b0011);
    checkOutput("rspKeep", 32'({rdata0, rdata1}), 32'({e0, e1}));
    lastRsp[0] = e0;
    lastRsp[1] = e1;
  endtask

  task automatic doWrite(input logic [8:0] a, input logic [7:0] d);
    applyStimulus(1'b1, a, d);
    reqValid = 1'b0;
    writeBody(a, d);
  endtask

  task automatic doRead(input logic [8:0] a, input int hold, input bit pulse);
    applyStimulus(1'b0, a, 8'h00);
    reqValid = 1'b0;
    readBody(a, hold, pulse);
  endtask

  // Safety net so the run always ends even if the design stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    logic [8:0] pool [8];
    logic [8:0] a;
    pool = '{9'h000, 9'h001, 9'h003, 9'h010, 9'h0FF, 9'h100, 9'h1FE, 9'h1FF};
    rstN     = 1'b0;
    reqValid = 1'b0;
    reqWe    = 1'b0;
    reqAddr  = '0;
    reqWdata = '0;
    rspReady = 1'b0;
    lastRsp[0] = 8'h00;
    lastRsp[1] = 8'h00;
    for (int i = 0; i < 512; i++) begin
      known[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    checkResetOutputs();
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", 32'({ready0, ready1}), 32'h3);

    $display("[TB] write 0xA5 to byte 0x003");
    doWrite(9'h003, 8'hA5);
    checkOutput("a5Bits0", 32'(ramBits(0, 9'h003)), 32'hA5);
    checkOutput("a5Bits1", 32'(ramBits(1, 9'h003)), 32'hA5);
    doRead(9'h003, 0, 1'b0);

    $display("[TB] write 0x01 to top byte 0x1FF");
    doWrite(9'h1FF, 8'h01);
    checkOutput("topBits0", 32'(ramBits(0, 9'h1FF)), 32'h01);
    checkOutput("topBits1", 32'(ramBits(1, 9'h1FF)), 32'h80);
    doRead(9'h1FF, 0, 1'b0);

    $display("[TB] response held five cycles with a request pulse");
    doRead(9'h003, 5, 1'b1);
    checkOutput("pulseIgnored", 32'(ramBits(0, 9'h002)), 32'(ramBits(0, 9'h002)) & 32'hFF);

    $display("[TB] back-to-back write then read");
    applyStimulus(1'b1, 9'h0AB, 8'h3C);
    reqWe    = 1'b0;
    reqAddr  = 9'h154;
    reqWdata = 8'hC3;
    writeBody(9'h0AB, 8'h3C);
    reqAddr = 9'h0AB;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    readBody(9'h0AB, 1, 1'b0);

    $display("[TB] reset during write of 0xFF to byte 0x010");
    doWrite(9'h010, 8'h00);
    applyStimulus(1'b1, 9'h010, 8'hFF);
    reqValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkResetOutputs();
    modelMem[0][9'h010] = 8'h0F;
    modelMem[1][9'h010] = 8'hF0;
    checkOutput("abortBits0", 32'(ramBits(0, 9'h010)), 32'h0F);
    checkOutput("abortBits1", 32'(ramBits(1, 9'h010)), 32'h0F);
    @(negedge clk);
    rstN = 1'b1;
    lastRsp[0] = 8'h00;
    lastRsp[1] = 8'h00;
    @(negedge clk);
    checkOutput("readyAfterAbort", 32'({ready0, ready1}), 32'h3);
    doRead(9'h010, 0, 1'b0);

    $display("[TB] reset while a response is pending");
    applyStimulus(1'b0, 9'h003, 8'h00);
    reqValid = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("respPending", 32'({rspValid0, rspValid1}), 32'h3);
    rstN = 1'b0;
    #1;
    checkResetOutputs();
    @(negedge clk);
    rstN = 1'b1;
    lastRsp[0] = 8'h00;
    lastRsp[1] = 8'h00;
    @(negedge clk);
    checkOutput("respDiscarded", 32'({rspValid0, rspValid1, ready0, ready1}), 32'b0011);
    checkOutput("rdataCleared", 32'({rdata0, rdata1}), 32'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      a = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1 || !known[a]) begin
        doWrite(a, 8'($urandom));
      end else begin
        doRead(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
